// File: rtl/sram2_controller.sv
// sram2_controller: stores finished AES blocks to consecutive SRAM2 addresses from a host-supplied base,
// holding each write for WRITE_CYCLES cycles with a turnaround gap, and pulses done after num_blocks writes.
module sram2_controller #(
  parameter int ADDR_SIZE_BITS = 8,
  parameter int ACCESS_SIZE_BITS = 128,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [ADDR_SIZE_BITS-1:0]   s_addr,
  input  logic [ADDR_SIZE_BITS-1:0]   num_blocks,
  input  logic                        blk_valid,
  input  logic [ACCESS_SIZE_BITS-1:0] blk_data,
  output logic                        blk_ready,
  output logic                        w_en,
  output logic [ADDR_SIZE_BITS-1:0]   w_addr,
  output logic [ACCESS_SIZE_BITS-1:0] w_data,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = $clog2(WRITE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_BLK, WRITE, GAP, DONE} state_t;
  state_t state;
  logic [ADDR_SIZE_BITS-1:0] addr_r, cnt_r;
  logic [ACCESS_SIZE_BITS-1:0] data_r;
  logic [CW-1:0] wcnt;
  // The address and data registers drive the bus directly, so they hold through GAP and clear on return to IDLE.
  assign w_addr = addr_r;
  assign w_data = data_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_r <= '0;
      cnt_r <= '0;
      data_r <= '0;
      wcnt <= '0;
      blk_ready <= 1'b0;
      w_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          addr_r <= s_addr;
          cnt_r <= num_blocks;
          busy <= 1'b1;
          state <= (num_blocks == '0) ? DONE : WAIT_BLK;
          done <= (num_blocks == '0);
          blk_ready <= (num_blocks != '0);
        end
        WAIT_BLK: if (blk_valid) begin
          data_r <= blk_data;
          wcnt <= '0;
          blk_ready <= 1'b0;
          w_en <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == CW'(WRITE_CYCLES - 1)) begin
            w_en <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          addr_r <= addr_r + 1'b1;
          cnt_r <= cnt_r - 1'b1;
          state <= (cnt_r == ADDR_SIZE_BITS'(1)) ? DONE : WAIT_BLK;
          done <= (cnt_r == ADDR_SIZE_BITS'(1));
          blk_ready <= (cnt_r != ADDR_SIZE_BITS'(1));
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          addr_r <= '0;
          data_r <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram2_controller.sv
// tb_sram2_controller: directed and random runs checked every cycle against a timeline model of the controller.
module tb_sram2_controller;
  localparam int W = 2;
  logic clk = 0, rst = 1, enable = 0, blk_valid = 0;
  logic [7:0] s_addr = 0, num_blocks = 0;
  logic [127:0] blk_data = 0;
  logic blk_ready, w_en, busy, done;
  logic [7:0] w_addr;
  logic [127:0] w_data;

  sram2_controller dut (
    .clk(clk), .rst(rst), .enable(enable), .s_addr(s_addr), .num_blocks(num_blocks),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready), .w_en(w_en),
    .w_addr(w_addr), .w_data(w_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rdy, wen, bsy, dn;
    logic [7:0] addr;
    logic [127:0] data;
  } exp_t;

  localparam logic [127:0] LIT = 128'h00112233445566778899AABBCCDDEEFF;
  int total = 0, bad = 0, cyc = 0;
  bit run = 0;
  int ts = 0, n = 0;
  logic [7:0] base = 0;
  int hs[$];
  logic [127:0] hd[$];
  logic [127:0] sram [256];
  logic [127:0] exp_mem [256];
  int dones = 0, hss = 0, wens = 0, done_cyc = 0;
  logic wen_prev = 0;
  int wa_q[$], wc_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // A run is a start cycle plus the list of handshake cycles; every output follows from those by offset.
  function automatic int fin_cyc(int c);
    int k = hs.size();
    if (n == 0) return ts + 1;
    return (k == n) ? hs[k-1] + W + 2 : c + 1;
  endfunction

  function automatic exp_t model(int c);
    exp_t e = '0;
    int k = hs.size();
    int last = (k > 0) ? hs[k-1] : ts;
    if (!run || c <= ts || c > fin_cyc(c)) return e;
    e.bsy = 1'b1;
    e.dn = (k == n) && (c == fin_cyc(c));
    e.rdy = (k < n) && (k == 0 || c >= last + W + 2);
    e.wen = (k > 0) && (c > last) && (c <= last + W);
    if (k > 0) begin
      e.addr = base + 8'(k - 1);
      e.data = hd[k-1];
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = model(cyc);
    if (rst) run = 0;
    else if (!run || cyc > fin_cyc(cyc)) begin
      if (enable) begin
        run = 1; ts = cyc; n = int'(num_blocks); base = s_addr;
        hs.delete(); hd.delete();
      end
    end else if (e.rdy && blk_valid) begin
      exp_mem[base + 8'(hs.size())] = blk_data;
      hs.push_back(cyc);
      hd.push_back(blk_data);
    end
    cyc++;
  end

  always @(negedge clk) begin
    exp_t e;
    e = model(cyc);
    chk("blk_ready", 128'(blk_ready), 128'(e.rdy));
    chk("w_en", 128'(w_en), 128'(e.wen));
    chk("busy", 128'(busy), 128'(e.bsy));
    chk("done", 128'(done), 128'(e.dn));
    if (e.wen) begin
      chk("w_addr", 128'(w_addr), 128'(e.addr));
      chk("w_data", w_data, e.data);
    end
    if (!e.bsy) begin
      chk("idle_addr", 128'(w_addr), 128'(0));
      chk("idle_data", w_data, 128'(0));
    end
    if (w_en) begin
      sram[w_addr] = w_data;
      wens++;
    end
    if (w_en && !wen_prev) begin
      wa_q.push_back(int'(w_addr));
      wc_q.push_back(cyc);
    end
    wen_prev = w_en;
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (blk_ready && blk_valid) hss++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] b, input logic [7:0] nb, output int t);
    enable = 1; s_addr = b; num_blocks = nb; t = cyc;
    tick();
    enable = 0; s_addr = 8'($urandom); num_blocks = 8'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int d0 = dones;
    for (int i = 0; i < 400 && dones == d0; i++) @(negedge clk);
    chk({nm, "_done_count"}, 128'(dones - d0), 128'(1));
    tick();
  endtask

  task automatic single(input string nm);
    int t, h0, w0, q0;
    blk_data = LIT; blk_valid = 1;
    h0 = hss; w0 = wens; q0 = wa_q.size();
    start(8'h10, 8'd1, t);
    wait_done(nm);
    chk({nm, "_latency"}, 128'(done_cyc - t), 128'(5));
    chk({nm, "_wen_cycles"}, 128'(wens - w0), 128'(2));
    chk({nm, "_handshakes"}, 128'(hss - h0), 128'(1));
    chk({nm, "_addr"}, 128'(wa_q[q0]), 128'(8'h10));
    chk({nm, "_mem"}, sram[8'h10], LIT);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, h0, d0, w0, q0, nb, rc;
    logic [7:0] rb;
    logic [127:0] stall_data;
    bit rr, fin;
    for (int i = 0; i < 256; i++) begin
      sram[i] = '0;
      exp_mem[i] = '0;
    end
    repeat (3) tick();
    rst = 0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_wen", 128'(w_en), 128'(0));
    chk("rst_ready", 128'(blk_ready), 128'(0));

    single("single");

    q0 = wa_q.size(); h0 = hss;
    start(8'h00, 8'd3, t);
    wait_done("b2b");
    chk("b2b_handshakes", 128'(hss - h0), 128'(3));
    for (int i = 0; i < 3; i++) chk("b2b_addr", 128'(wa_q[q0+i]), 128'(i));
    for (int i = 1; i < 3; i++) chk("b2b_spacing", 128'(wc_q[q0+i] - wc_q[q0+i-1]), 128'(4));

    q0 = wa_q.size(); h0 = hss;
    blk_data = {$urandom, $urandom, $urandom, $urandom};
    start(8'h40, 8'd2, t);
    tick();
    blk_valid = 0;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_ready", 128'(blk_ready), 128'(1));
      chk("stall_wen", 128'(w_en), 128'(0));
      tick();
    end
    stall_data = {$urandom, $urandom, $urandom, $urandom};
    blk_data = stall_data; blk_valid = 1;
    wait_done("stall");
    chk("stall_handshakes", 128'(hss - h0), 128'(2));
    chk("stall_addr2", 128'(wa_q[q0+1]), 128'(8'h41));
    chk("stall_mem2", sram[8'h41], stall_data);

    q0 = wa_q.size();
    start(8'hFF, 8'd2, t);
    wait_done("wrap");
    chk("wrap_addr0", 128'(wa_q[q0]), 128'(8'hFF));
    chk("wrap_addr1", 128'(wa_q[q0+1]), 128'(8'h00));

    w0 = wens;
    start(8'h33, 8'd0, t);
    wait_done("zero");
    chk("zero_latency", 128'(done_cyc - t), 128'(1));
    chk("zero_no_write", 128'(wens - w0), 128'(0));

    q0 = wa_q.size(); h0 = hss;
    start(8'h20, 8'd2, t);
    tick();
    enable = 1; s_addr = 8'h80; num_blocks = 8'd7;
    tick();
    enable = 0;
    wait_done("ign_en");
    chk("ign_en_handshakes", 128'(hss - h0), 128'(2));
    chk("ign_en_addr0", 128'(wa_q[q0]), 128'(8'h20));
    chk("ign_en_addr1", 128'(wa_q[q0+1]), 128'(8'h21));

    d0 = dones;
    start(8'h50, 8'd1, t);
    for (int i = 0; i < 20 && !w_en; i++) @(negedge clk);
    chk("rmw_write_seen", 128'(w_en), 128'(1));
    rst = 1;
    tick();
    rst = 0;
    chk("rmw_wen", 128'(w_en), 128'(0));
    chk("rmw_busy", 128'(busy), 128'(0));
    chk("rmw_ready", 128'(blk_ready), 128'(0));
    repeat (10) tick();
    chk("rmw_no_done", 128'(dones - d0), 128'(0));
    single("after_rst");

    for (int r = 0; r < 30; r++) begin
      nb = $urandom_range(0, 5);
      rb = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      rr = ($urandom_range(0, 7) == 0);
      rc = $urandom_range(1, 12);
      fin = 0;
      d0 = dones;
      start(rb, 8'(nb), t);
      for (int i = 0; i < 300 && !fin; i++) begin
        blk_valid = ($urandom_range(0, 2) != 0);
        blk_data = {$urandom, $urandom, $urandom, $urandom};
        enable = ($urandom_range(0, 9) == 0);
        s_addr = 8'($urandom);
        num_blocks = 8'($urandom);
        rst = rr && (i == rc);
        @(negedge clk);
        fin = (dones != d0) || rst;
        tick();
      end
      rst = 0; enable = 0; blk_valid = 0;
      chk("rand_run_end", 128'(fin), 128'(1));
      tick();
    end

    for (int i = 0; i < 256; i++) chk("mem_dump", sram[i], exp_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram2_controller.md
# sram2_controller

Output-side SRAM controller for the AES chip. Accepts finished 128-bit blocks from the cipher datapath over a valid/ready handshake and writes them to consecutive addresses of the off-chip output SRAM (SRAM2), starting at a host-supplied base address. It is the writer counterpart of `sram1_controller`, which reads input blocks from SRAM1. It pulses `done` when the programmed block count has been stored.

## Interface

Parameters:
- `ADDR_SIZE_BITS`, 8: SRAM word-address width.
- `ACCESS_SIZE_BITS`, 128: one SRAM access, equal to one AES block.
- `WRITE_CYCLES`, 2: cycles that `w_en`, `w_addr` and `w_data` are held stable per SRAM write; must be at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: start pulse. Sampled only in IDLE.
- `s_addr` in ADDR_SIZE_BITS: base write address. Latched on start.
- `num_blocks` in ADDR_SIZE_BITS: number of blocks to store. Latched on start.
- `blk_valid` in 1: the datapath has a finished block on `blk_data`.
- `blk_data` in ACCESS_SIZE_BITS: finished cipher block.
- `blk_ready` out 1: the controller can accept a block.
- `w_en` out 1: SRAM2 write enable. Also serves as the top-level tri-state enable for the data bus.
- `w_addr` out ADDR_SIZE_BITS: SRAM2 address.
- `w_data` out ACCESS_SIZE_BITS: write data. The top level drives the bidir bus with `w_data` when `w_en` is high, else `'z`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation

- The FSM states are IDLE, WAIT_BLK, WRITE, GAP and DONE. All outputs decode from registered state (Moore); none is combinational from inputs.
- **IDLE**
  - All outputs are 0.
  - When `enable`=1: latch `addr_r`←`s_addr` and `cnt_r`←`num_blocks`.
  - If `num_blocks`=0, go to DONE. Otherwise go to WAIT_BLK.
- **WAIT_BLK**
  - `blk_ready`=1.
  - When `blk_valid`&&`blk_ready`: capture `blk_data` into `data_r`, clear the write counter and go to WRITE.
  - While `blk_valid`=0, stay in WAIT_BLK indefinitely.
- **WRITE**
  - `w_en`=1, `w_addr`=`addr_r`, `w_data`=`data_r`. All three are stable for exactly WRITE_CYCLES cycles.
  - `blk_ready`=0.
  - After the last write cycle, go to GAP.
- **GAP**
  - `w_en`=0; `w_addr` and `w_data` keep their last values.
  - This is one mandatory bus-turnaround cycle.
  - On exit: `addr_r`←`addr_r`+1 (modulo 2^ADDR_SIZE_BITS, so 0xFF wraps to 0x00) and `cnt_r`←`cnt_r`−1.
  - Go to DONE if the old `cnt_r` was 1, else to WAIT_BLK.
- **DONE**
  - `done`=1 for exactly one cycle, `busy`=1, then go to IDLE.
- `enable` is ignored in every state except IDLE.
- `s_addr` and `num_blocks` may change after the start cycle without effect.
- `blk_valid` outside WAIT_BLK is ignored; the datapath must hold the block until it sees `blk_ready`.
- Address arithmetic is unsigned ADDR_SIZE_BITS, with wrap and no error flag. The block count is unsigned, so up to 255 blocks per run.

## Timing

- Reset: state=IDLE, and `addr_r`, `cnt_r`, `data_r` and every output go to 0 at the next edge.
  - Reset mid-WRITE deasserts `w_en` at that edge.
  - The partial write is not resumed and `done` is not issued.
- Start latency: `enable` in cycle T gives `busy`=1 and `blk_ready`=1 in T+1.
- Handshake in cycle H gives `w_en`=1 in H+1 … H+WRITE_CYCLES and GAP in H+WRITE_CYCLES+1.
  - The next `blk_ready` is in H+WRITE_CYCLES+2.
  - If that was the last block, `done` is in H+WRITE_CYCLES+2 instead.
- Maximum throughput is one block per WRITE_CYCLES+2 cycles (4 with the default).
- `num_blocks`=0: `enable` in T gives `done` in T+1 and IDLE in T+2, with no `w_en` activity.
- A new `enable` is accepted in the cycle after `done` (IDLE).

## Test plan

- **Single block:** reset, then `enable` with `s_addr`=0x10, `num_blocks`=1, and `blk_data`=0x00112233445566778899AABBCCDDEEFF with `blk_valid` held high.
  - `w_en` is high for 2 cycles at `w_addr`=0x10 with that data.
  - `done` pulses 4 cycles after the handshake.
  - SRAM2 dump shows the block at 0x10.
- **Back-to-back:** `s_addr`=0x00, `num_blocks`=3, `blk_valid` always 1.
  - Writes go to 0x00, 0x01, 0x02, 4 cycles apart.
  - Exactly 3 handshakes, then one `done`.
- **Stalled producer:** `num_blocks`=2, with `blk_valid` low for 10 cycles before the second block.
  - `blk_ready` stays high and `w_en` stays low throughout the stall.
  - The second write lands at base+1 after valid rises.
- **Address wrap:** `s_addr`=0xFF, `num_blocks`=2 → writes at 0xFF then 0x00.
- **Zero count and ignored enable:**
  - `num_blocks`=0 → `done` one cycle after `enable`, with no write.
  - Pulsing `enable` mid-run with other values changes neither address nor count.
- **Reset mid-write:** assert `rst` during the first WRITE cycle.
  - `w_en`, `busy` and `blk_ready` are 0 on the next edge, and `done` never pulses.
  - A fresh start afterwards behaves as in the single-block test.
